microwave_control_unit: RTL and testbench

- Control FSM for the microwave oven, directly upstream of the countdown timer.
- Turns start/stop buttons, the door switch, keypad-entry strobes and the timer's zero flag into the timer's enable, load and clear controls, plus magnetron and beeper drives.
- All outputs are registered and wire straight onto the timer's control inputs.

---
 rtl/microwave_pkg.sv | 9 +
 rtl/microwave_control_unit_if.sv | 12 +
 rtl/microwave_control_unit_button_conditioner.sv | 49 ++++
 rtl/microwave_control_unit.sv | 81 ++++++++
 tb/tb_microwave_control_unit.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/microwave_pkg.sv
// microwave_pkg: shared state encoding and parameter defaults for the microwave control unit.
package microwave_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COOK  = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    localparam int BEEP_CYCLES_DEF     = 8;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
endpackage

// File: rtl/microwave_control_unit_if.sv
// microwave_control_unit_if: control unit <-> countdown timer bundle.
interface microwave_control_unit_if;
    logic       keypad_valid;
    logic       timer_zero;
    logic       mag_on;
    logic       timer_load;
    logic       timer_clr_n;
    logic       done_beep;
    logic [1:0] state;
    modport master (input keypad_valid, timer_zero, output mag_on, timer_load, timer_clr_n, done_beep, state);
    modport slave  (output keypad_valid, timer_zero, input mag_on, timer_load, timer_clr_n, done_beep, state);
endinterface

// File: rtl/microwave_control_unit_button_conditioner.sv
// button_conditioner: synchronizer, optional debouncer (CTRL_DEBOUNCE_EN) and press detector for one button.
module button_conditioner
    import microwave_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic clearn,
    input  logic btn_n,
    output logic press
);
    logic s1, lvl, prev;
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            s1   <= 1'b1;
            prev <= 1'b1;
        end else begin
            s1   <= btn_n;
            prev <= lvl;
        end
    end
`ifdef CTRL_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] cnt;
    // lvl doubles as the second synchronizer flop; it only moves after a full run of differing samples
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            lvl <= 1'b1;
            cnt <= '0;
        end else if (s1 == lvl) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            lvl <= s1;
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
`else
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) lvl <= 1'b1;
        else         lvl <= s1;
    end
`endif
    assign press = prev & ~lvl;
endmodule

// File: rtl/microwave_control_unit.sv
// microwave_control_unit: oven control FSM driving the countdown timer, magnetron and beeper.
// Optional button debouncing via CTRL_DEBOUNCE_EN.
module microwave_control_unit
    import microwave_pkg::*;
#(
    parameter int BEEP_CYCLES     = BEEP_CYCLES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                       clk,
    input  logic                       clearn,
    input  logic                       startn,
    input  logic                       stopn,
    input  logic                       door_closed,
    microwave_control_unit_if.master   tif
);
    localparam int BW = $clog2(BEEP_CYCLES + 1);
    if (BEEP_CYCLES < 1) begin : g_bad_beep
        $error("BEEP_CYCLES must be at least 1");
    end
    logic start_press, stop_press, start_go;
    logic d1, door;
    logic [1:0] nxt;
    logic nload, nclr;
    logic [BW-1:0] beep_cnt, ncnt;
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk(clk), .clearn(clearn), .btn_n(startn), .press(start_press)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop (
        .clk(clk), .clearn(clearn), .btn_n(stopn), .press(stop_press)
    );
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            d1   <= 1'b0;
            door <= 1'b0;
        end else begin
            d1   <= door_closed;
            door <= d1;
        end
    end
    assign start_go = start_press & ~stop_press;
    always_comb begin
        nxt   = tif.state;
        nload = 1'b0;
        nclr  = 1'b1;
        ncnt  = beep_cnt;
        case (tif.state)
            ST_IDLE: begin
                nload = tif.keypad_valid;
                nclr  = ~stop_press;
                nxt   = (start_go && door && !tif.timer_zero) ? ST_COOK : ST_IDLE;
            end
            ST_COOK: nxt = tif.timer_zero ? ST_DONE : (!door || stop_press) ? ST_PAUSE : ST_COOK;
            ST_PAUSE: begin
                nclr = ~stop_press;
                nxt  = stop_press ? ST_IDLE : (start_go && door) ? ST_COOK : ST_PAUSE;
            end
            default: begin
                nxt  = (start_press || stop_press || beep_cnt == BW'(BEEP_CYCLES - 1)) ? ST_IDLE : ST_DONE;
                ncnt = (nxt == ST_DONE) ? beep_cnt + BW'(1) : '0;
            end
        endcase
        if (nxt == ST_DONE && tif.state != ST_DONE) ncnt = '0;
    end
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            tif.state       <= ST_IDLE;
            tif.mag_on      <= 1'b0;
            tif.timer_load  <= 1'b0;
            tif.timer_clr_n <= 1'b1;
            tif.done_beep   <= 1'b0;
            beep_cnt        <= '0;
        end else begin
            tif.state       <= nxt;
            tif.mag_on      <= nxt == ST_COOK;
            tif.timer_load  <= nload;
            tif.timer_clr_n <= nclr;
            tif.done_beep   <= nxt == ST_DONE;
            beep_cnt        <= ncnt;
        end
    end
endmodule

// File: tb/tb_microwave_control_unit.sv
// tb_microwave_control_unit: directed test-plan steps plus randomized traffic against a behavioural model.
module tb_microwave_control_unit;
    localparam int BEEP = 8;
    localparam int DB   = 4;
`ifdef CTRL_DEBOUNCE_EN
    localparam int LAT = 3 + DB - 1;
`else
    localparam int LAT = 3;
`endif
    logic clk = 1'b0, clearn = 1'b0, startn = 1'b1, stopn = 1'b1, door_closed = 1'b0;
    microwave_control_unit_if tif();
    microwave_control_unit #(.BEEP_CYCLES(BEEP), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .clearn(clearn), .startn(startn), .stopn(stopn),
        .door_closed(door_closed), .tif(tif)
    );
    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    bit cmp_en = 1'b0;

    // model: raw input histories (index 0 = sample at the latest edge) and spec-level state
    logic sh[16], ph[16], dh[4];
    logic acc_s, acc_p, fell_s, fell_p;
    int m_st, m_cnt;
    logic m_mag, m_load, m_clr, m_beep;

    task automatic cmp(input string n, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", n, got, exp, $time);
        end
    endtask

    task automatic lit(input string n, input int got, input int mdl, input int exp);
        cmp(n, got, exp);
        cmp({n, "_model"}, mdl, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

`ifdef CTRL_DEBOUNCE_EN
    function automatic bit all_differ(input logic h[16], input logic a);
        for (int i = 1; i <= DB; i++) if (h[i] == a) return 1'b0;
        return 1'b1;
    endfunction
`endif

    always @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            for (int i = 0; i < 16; i++) begin sh[i] = 1'b1; ph[i] = 1'b1; end
            for (int i = 0; i < 4; i++) dh[i] = 1'b0;
            acc_s = 1'b1; acc_p = 1'b1; fell_s = 1'b0; fell_p = 1'b0;
            m_st = 0; m_cnt = 0;
            m_mag = 1'b0; m_load = 1'b0; m_clr = 1'b1; m_beep = 1'b0;
        end else begin
            bit ps, pp, ds;
            int nst;
            for (int i = 15; i > 0; i--) begin sh[i] = sh[i-1]; ph[i] = ph[i-1]; end
            for (int i = 3; i > 0; i--) dh[i] = dh[i-1];
            sh[0] = startn; ph[0] = stopn; dh[0] = door_closed;
            ds = dh[2];
`ifdef CTRL_DEBOUNCE_EN
            ps = fell_s; pp = fell_p;
            fell_s = 1'b0; fell_p = 1'b0;
            if (all_differ(sh, acc_s)) begin acc_s = ~acc_s; fell_s = !acc_s; end
            if (all_differ(ph, acc_p)) begin acc_p = ~acc_p; fell_p = !acc_p; end
`else
            ps = !sh[2] && sh[3];
            pp = !ph[2] && ph[3];
`endif
            m_load = 1'b0; m_clr = 1'b1; nst = m_st;
            if (m_st == 0) begin
                m_load = tif.keypad_valid;
                if (pp) m_clr = 1'b0;
                else if (ps && ds && !tif.timer_zero) nst = 1;
            end else if (m_st == 1) begin
                if (tif.timer_zero) nst = 3;
                else if (!ds || pp) nst = 2;
            end else if (m_st == 2) begin
                if (pp) begin nst = 0; m_clr = 1'b0; end
                else if (ps && ds) nst = 1;
            end else begin
                if (ps || pp || m_cnt == BEEP - 1) nst = 0;
                else m_cnt++;
            end
            if (nst == 3 && m_st != 3) m_cnt = 0;
            m_st = nst;
            m_mag = (m_st == 1);
            m_beep = (m_st == 3);
        end
    end

    always @(negedge clk) begin
        if (cmp_en && clearn) begin
            cmp("state", tif.state, m_st);
            cmp("mag_on", tif.mag_on, m_mag);
            cmp("timer_load", tif.timer_load, m_load);
            cmp("timer_clr_n", tif.timer_clr_n, m_clr);
            cmp("done_beep", tif.done_beep, m_beep);
        end
    end

    task automatic press_start(input int exp_state);
        startn = 1'b0;
        tick(LAT);
        lit("press_start", tif.state, m_st, exp_state);
        startn = 1'b1;
        tick(LAT + 1);
    endtask

    initial begin
        int hs = 0, hp = 0;
        tif.keypad_valid = 1'b0;
        tif.timer_zero = 1'b0;
        tick(2);
        clearn = 1'b1;
        cmp_en = 1'b1;
        lit("rst_state", tif.state, m_st, 0);
        lit("rst_mag", tif.mag_on, m_mag, 0);
        lit("rst_clr_n", tif.timer_clr_n, m_clr, 1);
        lit("rst_load", tif.timer_load, m_load, 0);
        // 1: keypad strobe in IDLE
        door_closed = 1'b1;
        tick(3);
        tif.keypad_valid = 1'b1;
        tick(1);
        tif.keypad_valid = 1'b0;
        lit("kp_load_hi", tif.timer_load, m_load, 1);
        tick(1);
        lit("kp_load_lo", tif.timer_load, m_load, 0);
        lit("kp_state", tif.state, m_st, 0);
        // 2: start held for 5 cycles
        startn = 1'b0;
        tick(LAT - 1);
        lit("start_early", tif.state, m_st, 0);
        tick(1);
        lit("start_cook", tif.state, m_st, 1);
        lit("start_mag", tif.mag_on, m_mag, 1);
        tick(2);
        startn = 1'b1;
        tick(LAT + 1);
        lit("start_hold", tif.state, m_st, 1);
        // 3: door open pauses, close and restart
        door_closed = 1'b0;
        tick(2);
        lit("door_early", tif.state, m_st, 1);
        tick(1);
        lit("door_pause", tif.state, m_st, 2);
        lit("door_mag", tif.mag_on, m_mag, 0);
        door_closed = 1'b1;
        tick(3);
        press_start(1);
        // 4: zero and door-open together
        tif.timer_zero = 1'b1;
        door_closed = 1'b0;
        tick(1);
        tif.timer_zero = 1'b0;
        door_closed = 1'b1;
        lit("zero_done", tif.state, m_st, 3);
        lit("zero_mag", tif.mag_on, m_mag, 0);
        lit("beep_1", tif.done_beep, m_beep, 1);
        for (int k = 2; k <= BEEP; k++) begin
            tick(1);
            lit("beep_n", tif.done_beep, m_beep, 1);
        end
        tick(1);
        lit("beep_end_state", tif.state, m_st, 0);
        lit("beep_end", tif.done_beep, m_beep, 0);
        tick(3);
        // 5: simultaneous start+stop in PAUSE, then start with zero flag
        press_start(1);
        stopn = 1'b0;
        tick(LAT);
        lit("stop_pause", tif.state, m_st, 2);
        stopn = 1'b1;
        tick(LAT + 1);
        startn = 1'b0;
        stopn = 1'b0;
        tick(LAT - 1);
        lit("both_early", tif.state, m_st, 2);
        tick(1);
        lit("both_idle", tif.state, m_st, 0);
        lit("both_clr", tif.timer_clr_n, m_clr, 0);
        tick(1);
        lit("both_clr_end", tif.timer_clr_n, m_clr, 1);
        startn = 1'b1;
        stopn = 1'b1;
        tick(LAT + 1);
        tif.timer_zero = 1'b1;
        press_start(0);
        tif.timer_zero = 1'b0;
        // 6: asynchronous reset mid-cook
        press_start(1);
        #2 clearn = 1'b0;
        #1 lit("arst_mag", tif.mag_on, m_mag, 0);
        lit("arst_state", tif.state, m_st, 0);
        tick(1);
        clearn = 1'b1;
        tick(3);
`ifdef CTRL_DEBOUNCE_EN
        startn = 1'b0;
        tick(2);
        startn = 1'b1;
        tick(10);
        lit("glitch", tif.state, m_st, 0);
        press_start(1);
`endif
        // randomized traffic
        repeat (3000) begin
            if (hs == 0) begin startn = ($urandom % 3) != 0; hs = $urandom_range(1, 8); end else hs--;
            if (hp == 0) begin stopn = ($urandom % 5) != 0; hp = $urandom_range(1, 8); end else hp--;
            if ($urandom % 30 == 0) door_closed = ~door_closed;
            tif.keypad_valid = ($urandom % 6) == 0;
            tif.timer_zero = ($urandom % 12) == 0;
            clearn = ($urandom % 700) != 0;
            tick(1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
